// File: rtl/av_regs_arbiter_if.sv
// av_regs_arbiter_if: requester command/response bundle plus the Avalon-MM register-port signals
interface av_regs_arbiter_if #(
  parameter int NREQ = 2,
  parameter int DW   = 32,
  parameter int AW   = 16
);
  logic [NREQ-1:0]                 req_valid_i;
  logic [NREQ-1:0]                 req_write_i;
  logic [NREQ-1:0][AW-1:0]         req_address_i;
  logic [NREQ-1:0][DW/8-1:0]       req_byteenable_i;
  logic [NREQ-1:0][DW-1:0]         req_writedata_i;
  logic [NREQ-1:0]                 req_ready_o;
  logic [NREQ-1:0]                 rsp_valid_o;
  logic [DW-1:0]                   rsp_readdata_o;
  logic [NREQ-1:0]                 rsp_err_o;
  logic [AW-1:0]                   m_address_o;
  logic [DW/8-1:0]                 m_byteenable_o;
  logic                            m_read_o;
  logic                            m_write_o;
  logic [DW-1:0]                   m_writedata_o;
  logic [DW-1:0]                   m_readdata_i;
  modport slave (
    input  req_valid_i, req_write_i, req_address_i, req_byteenable_i, req_writedata_i, m_readdata_i,
    output req_ready_o, rsp_valid_o, rsp_readdata_o, rsp_err_o,
           m_address_o, m_byteenable_o, m_read_o, m_write_o, m_writedata_o
  );
  modport master (
    output req_valid_i, req_write_i, req_address_i, req_byteenable_i, req_writedata_i, m_readdata_i,
    input  req_ready_o, rsp_valid_o, rsp_readdata_o, rsp_err_o,
           m_address_o, m_byteenable_o, m_read_o, m_write_o, m_writedata_o
  );
endinterface

// File: rtl/av_regs_arbiter.sv
// av_regs_arbiter: round-robin sharing of one Avalon-MM register port; AV_REGS_ARB_ADDR_CHECK_EN enables range checking
module av_regs_arbiter #(
  parameter int          NREQ     = 2,
  parameter int          DW       = 32,
  parameter int          AW       = 16,
  parameter int unsigned REGS_NUM = 2
) (
  input  logic             clk_i,
  input  logic             reset_i,
  av_regs_arbiter_if.slave bus
);
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
`ifdef AV_REGS_ARB_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT} state_t;
  state_t          r_state, w_next;
  logic [GW-1:0]   r_last, r_gnt, w_grant, w_idx;
  logic            w_any, w_oor, w_wr;
  logic            r_wr, r_err, r_read, r_write;
  logic [AW-1:0]   r_addr;
  logic [DW/8-1:0] r_be;
  logic [DW-1:0]   r_wdata, r_rdata;
  logic [NREQ-1:0] r_ready, r_rvalid, r_rerr;
  // Scan downward so the requester closest after last_grant is the final assignment.
  always_comb begin
    w_any   = |bus.req_valid_i;
    w_grant = r_last;
    w_idx   = r_last;
    for (int i = NREQ; i >= 1; i--) begin
      w_idx = GW'((int'(r_last) + i) % NREQ);
      w_grant = bus.req_valid_i[w_idx] ? w_idx : w_grant;
    end
    w_wr   = bus.req_write_i[w_grant];
    w_oor  = CHK && (bus.req_address_i[w_grant] >= AW'(REGS_NUM));
    w_next = (r_state == IDLE) ? (w_any ? ISSUE : IDLE) :
             (r_state == ISSUE && !r_wr) ? RD_WAIT : IDLE;
  end
  always_ff @(posedge clk_i)
    r_state <= reset_i ? IDLE : w_next;
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_last   <= GW'(NREQ - 1);
      r_gnt    <= '0;
      r_wr     <= 1'b0;
      r_err    <= 1'b0;
      r_read   <= 1'b0;
      r_write  <= 1'b0;
      r_addr   <= '0;
      r_be     <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_ready  <= '0;
      r_rvalid <= '0;
      r_rerr   <= '0;
    end else begin
      r_ready  <= '0;
      r_rvalid <= '0;
      r_rerr   <= '0;
      r_read   <= 1'b0;
      r_write  <= 1'b0;
      if (r_state == IDLE && w_any) begin
        r_gnt            <= w_grant;
        r_last           <= w_grant;
        r_wr             <= w_wr;
        r_err            <= w_oor;
        r_addr           <= bus.req_address_i[w_grant];
        r_be             <= bus.req_byteenable_i[w_grant];
        r_wdata          <= bus.req_writedata_i[w_grant];
        r_ready[w_grant] <= 1'b1;
        r_rerr[w_grant]  <= w_oor && w_wr;
        r_read           <= !w_wr && !w_oor;
        r_write          <= w_wr && !w_oor;
      end
      if (r_state == RD_WAIT) begin
        r_rvalid[r_gnt] <= 1'b1;
        r_rerr[r_gnt]   <= r_err;
        r_rdata         <= r_err ? '0 : bus.m_readdata_i;
      end
    end
  end
  assign bus.req_ready_o    = r_ready;
  assign bus.rsp_valid_o    = r_rvalid;
  assign bus.rsp_readdata_o = r_rdata;
  assign bus.rsp_err_o      = r_rerr;
  assign bus.m_address_o    = r_addr;
  assign bus.m_byteenable_o = r_be;
  assign bus.m_read_o       = r_read;
  assign bus.m_write_o      = r_write;
  assign bus.m_writedata_o  = r_wdata;
endmodule
